// File: rtl/timer_host_sequencer.sv
// Avalon-MM master for the interval timer s1 port: turns single-beat commands
// into timer register access sequences and can service the timer irq on its own.
module timer_host_sequencer #(
    parameter bit AUTO_ACK = 1'b0,
    parameter int EVT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_cont,
    input  logic             cmd_ito,
    output logic             done,
    output logic [31:0]      snapshot,
    output logic             status_running,
    output logic             status_timeout,
    output logic [EVT_W-1:0] event_count,
    output logic [2:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [15:0]      writedata,
    input  logic [15:0]      readdata,
    input  logic             irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WR_SNAP,
        S_RD_SL, S_RD_SH, S_RD_CAP, S_RD_ST, S_WR_ST
    } state_t;

    state_t      state_r, next_state_s;
    logic        accept_s, auto_start_s, irq_service_s;
    logic [31:0] period_r;
    logic [1:0]  ctrl_shadow_r;
    logic        auto_r;
    logic        bus_cs_s, bus_wn_s;
    logic [2:0]  bus_addr_s;
    logic [15:0] bus_wd_s;

    assign irq_service_s = (AUTO_ACK == 1'b1) && irq;
    assign cmd_ready     = (state_r == S_IDLE) && !irq_service_s;

    // Next-state logic; a pending irq wins over a command in IDLE.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        auto_start_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (irq_service_s) begin
                    next_state_s = S_RD_ST;
                    auto_start_s = 1'b1;
                end else if (cmd_valid) begin
                    accept_s = 1'b1;
                    case (cmd_op)
                        2'd0:    next_state_s = S_WR_PL;
                        2'd1:    next_state_s = S_WR_CTL;
                        2'd2:    next_state_s = S_WR_SNAP;
                        2'd3:    next_state_s = S_RD_ST;
                        default: next_state_s = S_IDLE;
                    endcase
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_WR_PL:   next_state_s = S_WR_PH;
            S_WR_PH:   next_state_s = S_WR_CTL;
            S_WR_CTL:  next_state_s = S_IDLE;
            S_WR_SNAP: next_state_s = S_RD_SL;
            S_RD_SL:   next_state_s = S_RD_SH;
            S_RD_SH:   next_state_s = S_RD_CAP;
            S_RD_CAP:  next_state_s = S_IDLE;
            S_RD_ST:   next_state_s = S_WR_ST;
            S_WR_ST:   next_state_s = S_IDLE;
            default:   next_state_s = S_IDLE;
        endcase
    end

    // Bus values for the state being entered, so the registered bus lines up with it.
    always_comb begin
        bus_cs_s   = 1'b0;
        bus_wn_s   = 1'b1;
        bus_addr_s = 3'd0;
        bus_wd_s   = 16'd0;
        case (next_state_s)
            S_WR_PL: begin
                bus_cs_s = 1'b1; bus_wn_s = 1'b0; bus_addr_s = 3'd2;
                bus_wd_s = cmd_period[15:0];
            end
            S_WR_PH: begin
                bus_cs_s = 1'b1; bus_wn_s = 1'b0; bus_addr_s = 3'd3;
                bus_wd_s = period_r[31:16];
            end
            S_WR_CTL: begin
                bus_cs_s = 1'b1; bus_wn_s = 1'b0; bus_addr_s = 3'd1;
                // Entering straight from IDLE means STOP; otherwise the tail of PROGRAM.
                if (state_r == S_IDLE) begin
                    bus_wd_s = {12'd0, 2'b10, ctrl_shadow_r};
                end else begin
                    bus_wd_s = {12'd0, 2'b01, ctrl_shadow_r};
                end
            end
            S_WR_SNAP: begin
                bus_cs_s = 1'b1; bus_wn_s = 1'b0; bus_addr_s = 3'd4;
            end
            S_RD_SL: begin
                bus_cs_s = 1'b1; bus_addr_s = 3'd4;
            end
            S_RD_SH: begin
                bus_cs_s = 1'b1; bus_addr_s = 3'd5;
            end
            S_RD_ST: begin
                bus_cs_s = 1'b1; bus_addr_s = 3'd0;
            end
            S_WR_ST: begin
                bus_cs_s = 1'b1; bus_wn_s = 1'b0; bus_addr_s = 3'd0;
            end
            default: begin
                bus_cs_s = 1'b0;
            end
        endcase
    end

    // State register, latched command fields and the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            period_r      <= 32'd0;
            ctrl_shadow_r <= 2'b00;
            auto_r        <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (accept_s) begin
                period_r <= cmd_period;
                auto_r   <= 1'b0;
                if (cmd_op == 2'd0) begin
                    ctrl_shadow_r <= {cmd_cont, cmd_ito};
                end
            end else if (auto_start_s) begin
                auto_r <= 1'b1;
            end
            done <= !auto_r && ((state_r == S_WR_CTL) || (state_r == S_RD_CAP) ||
                                (state_r == S_WR_ST));
        end
    end

    // Registered Avalon-MM master outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            address    <= 3'd0;
            writedata  <= 16'd0;
        end else begin
            chipselect <= bus_cs_s;
            write_n    <= bus_wn_s;
            address    <= bus_addr_s;
            writedata  <= bus_wd_s;
        end
    end

    // Read data trails the address by one cycle, so each capture sits one state later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot       <= 32'd0;
            status_running <= 1'b0;
            status_timeout <= 1'b0;
            event_count    <= '0;
        end else begin
            if (state_r == S_RD_SH) begin
                snapshot[15:0] <= readdata;
            end
            if (state_r == S_RD_CAP) begin
                snapshot[31:16] <= readdata;
            end
            if (state_r == S_WR_ST) begin
                status_running <= readdata[1];
                status_timeout <= readdata[0];
                if (auto_r && readdata[0]) begin
                    event_count <= event_count + EVT_W'(1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_timer_host_sequencer.sv
// Scoreboard bench: a timer slave model plus a transaction-level predictor
// feeding queues that a negedge monitor checks against bus activity and done.
module tb_timer_host_sequencer;
    localparam int EVT_W = 3;

    logic             clk = 1'b0, reset_n = 1'b1;
    logic             cmd_valid = 1'b0, cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [31:0]      cmd_period = 32'd0;
    logic             cmd_cont = 1'b0, cmd_ito = 1'b0;
    logic             done, status_running, status_timeout;
    logic [31:0]      snapshot;
    logic [EVT_W-1:0] event_count;
    logic [2:0]       address;
    logic             chipselect, write_n, irq;
    logic [15:0]      writedata, readdata = 16'd0;

    timer_host_sequencer #(.AUTO_ACK(1'b1), .EVT_W(EVT_W)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ito(cmd_ito),
        .done(done), .snapshot(snapshot), .status_running(status_running),
        .status_timeout(status_timeout), .event_count(event_count), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- timer slave model ----------------
    logic        s_to = 1'b0, s_run = 1'b0, s_ito = 1'b0, s_cont = 1'b0, to_pulse = 1'b0;
    logic [31:0] s_period = 32'd0, s_snap = 32'd0, counter = 32'd0;
    assign irq = s_to & s_ito;

    always @(posedge clk) begin
        if (to_pulse) s_to <= 1'b1;
        if (chipselect && !write_n) begin
            case (address)
                3'd0: s_to <= 1'b0;
                3'd1: begin
                    s_ito  <= writedata[0];
                    s_cont <= writedata[1];
                    if (writedata[2]) s_run <= 1'b1;
                    else if (writedata[3]) s_run <= 1'b0;
                end
                3'd2: s_period[15:0]  <= writedata;
                3'd3: s_period[31:16] <= writedata;
                3'd4, 3'd5: s_snap <= counter;
                default: ;
            endcase
        end
        if (chipselect && write_n) begin
            case (address)
                3'd0: readdata <= {14'd0, s_run, s_to};
                3'd1: readdata <= {12'd0, 2'b00, s_cont, s_ito};
                3'd2: readdata <= s_period[15:0];
                3'd3: readdata <= s_period[31:16];
                3'd4: readdata <= s_snap[15:0];
                3'd5: readdata <= s_snap[31:16];
                default: readdata <= 16'd0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { bit wr; bit [2:0] addr; bit [15:0] data; int cyc; } bus_t;
    typedef struct { int cyc; bit [31:0] snap; bit [1:0] st; int ev; } done_t;
    bus_t  bus_q[$];
    done_t done_q[$];
    int    checks = 0, errors = 0;

    // Reference state: what the timer and the sequencer should hold.
    bit        m_ito = 1'b0, m_run = 1'b0, m_to = 1'b0;
    bit [1:0]  m_shadow = 2'b00, m_st = 2'b00;
    bit [31:0] m_snap = 32'd0;
    int        m_ev = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push_bus(input bit wr, input bit [2:0] a, input bit [15:0] d, input int c);
        bus_t b;
        b.wr = wr; b.addr = a; b.data = d; b.cyc = c;
        bus_q.push_back(b);
    endtask

    task automatic predict_auto(input int c);
        push_bus(1'b0, 3'd0, 16'd0, c);
        push_bus(1'b1, 3'd0, 16'd0, c + 1);
        m_st = {m_run, 1'b1};
        m_to = 1'b0;
        m_ev = (m_ev + 1) % (1 << EVT_W);
    endtask

    // k = acceptance edge; cycle k+j is the interval following edge k+j-1.
    task automatic predict(input int k, input bit [1:0] op, input bit [31:0] per,
                           input bit cont, input bit ito);
        done_t d;
        int lat;
        lat = 0;
        case (op)
            2'd0: begin
                m_shadow = {cont, ito};
                push_bus(1'b1, 3'd2, per[15:0], k + 1);
                push_bus(1'b1, 3'd3, per[31:16], k + 2);
                push_bus(1'b1, 3'd1, {12'd0, 2'b01, cont, ito}, k + 3);
                m_ito = ito; m_run = 1'b1; lat = 4;
            end
            2'd1: begin
                push_bus(1'b1, 3'd1, {12'd0, 2'b10, m_shadow}, k + 1);
                m_ito = m_shadow[0]; m_run = 1'b0; lat = 2;
            end
            2'd2: begin
                push_bus(1'b1, 3'd4, 16'd0, k + 1);
                push_bus(1'b0, 3'd4, 16'd0, k + 2);
                push_bus(1'b0, 3'd5, 16'd0, k + 3);
                m_snap = counter; lat = 5;
            end
            default: begin
                push_bus(1'b0, 3'd0, 16'd0, k + 1);
                push_bus(1'b1, 3'd0, 16'd0, k + 2);
                m_st = {m_run, m_to}; m_to = 1'b0; lat = 3;
            end
        endcase
        d.cyc = k + lat; d.snap = m_snap; d.st = m_st; d.ev = m_ev;
        done_q.push_back(d);
        if (m_to && m_ito) predict_auto(k + lat + 1);
    endtask

    // Monitor: every cycle out of reset, compare bus and done against the queues.
    bus_t  mb;
    done_t md;
    int    idx;
    always @(negedge clk) begin
        if (reset_n) begin
            idx = cyc + 1;
            if (chipselect) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bus: got addr=%0d write_n=%0b data=0x%04h required no access, cycle %0d",
                             address, write_n, writedata, idx);
                end else begin
                    mb = bus_q.pop_front();
                    chk("bus_write", 32'(!write_n), 32'(mb.wr));
                    chk("bus_addr", 32'(address), 32'(mb.addr));
                    if (mb.wr) chk("bus_wdata", 32'(writedata), 32'(mb.data));
                    chk("bus_cycle", 32'(idx), 32'(mb.cyc));
                end
            end else begin
                chk("bus_idle", 32'({write_n, address, writedata}), 32'({1'b1, 3'd0, 16'd0}));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 required 0, cycle %0d", idx);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", 32'(idx), 32'(md.cyc));
                    chk("snapshot", snapshot, md.snap);
                    chk("status", 32'({status_running, status_timeout}), 32'(md.st));
                    chk("event_count", 32'(event_count), 32'(md.ev));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit [1:0] op, input bit [31:0] per, input bit cont, input bit ito);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        cmd_op = op; cmd_period = per; cmd_cont = cont; cmd_ito = ito; cmd_valid = 1'b1;
        for (int t = 0; t < 60 && !acc; t++) begin
            #1;
            if (cmd_ready) begin
                predict(cyc + 1, op, per, cont, ito);
                acc = 1'b1;
                @(posedge clk);
                #1 cmd_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!acc) begin
            errors++;
            cmd_valid = 1'b0;
            $display("FAIL accept_timeout: got cmd_ready=0 for 60 cycles required acceptance, op=%0d", op);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (bus_q.size() != 0 || done_q.size() != 0); t++) @(negedge clk);
        chk("queues_drained", 32'(bus_q.size() + done_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic fire();
        int c;
        @(negedge clk);
        c = cyc;
        to_pulse = 1'b1;
        if (m_ito) predict_auto(c + 3);
        else m_to = 1'b1;
        @(posedge clk);
        #1 to_pulse = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_bus"}, 32'({chipselect, write_n, address, writedata}), 32'({1'b0, 1'b1, 3'd0, 16'd0}));
        chk({nm, "_done"}, 32'(done), 32'd0);
        chk({nm, "_snapshot"}, snapshot, 32'd0);
        chk({nm, "_status"}, 32'({status_running, status_timeout}), 32'd0);
        chk({nm, "_evt"}, 32'(event_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bit        sv_ito, sv_run;
        bit [1:0]  op;
        bit [31:0] per;
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        #1 chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        issue(2'd0, 32'h0001_86A0, 1'b1, 1'b1);
        drain();

        counter = 32'h0001_2345;
        issue(2'd2, 32'd0, 1'b0, 1'b0);
        drain();
        chk("snapshot_value", snapshot, 32'h0001_2345);

        issue(2'd0, 32'h0000_0400, 1'b1, 1'b0);
        issue(2'd1, 32'd0, 1'b0, 1'b0);
        drain();

        issue(2'd0, 32'h0000_1000, 1'b1, 1'b0);
        drain();
        fire();
        issue(2'd3, 32'd0, 1'b0, 1'b0);
        drain();
        chk("ack_status", 32'({status_running, status_timeout}), 32'd3);

        issue(2'd0, 32'h0000_0200, 1'b0, 1'b1);
        drain();
        fire();
        chk("ready_blocked_by_irq", 32'(cmd_ready), 32'd0);
        cmd_op = 2'd3; cmd_valid = 1'b1;
        issue(2'd3, 32'd0, 1'b0, 1'b0);
        drain();
        chk("auto_evt_one", 32'(event_count), 32'd1);

        for (int i = 0; i < 7; i++) begin
            fire();
            drain();
        end
        chk("evt_wrap_zero", 32'(event_count), 32'd0);
        fire();
        drain();
        chk("evt_after_wrap", 32'(event_count), 32'd1);

        sv_ito = m_ito; sv_run = m_run;
        issue(2'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("midseq_reset");
        bus_q.delete();
        done_q.delete();
        m_ito = sv_ito; m_run = sv_run;
        m_shadow = 2'b00; m_snap = 32'd0; m_st = 2'b00; m_ev = 0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        #1 chk("ready_after_midseq_reset", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            per = $urandom;
            if (op == 2'd2) begin
                drain();
                counter = $urandom;
            end
            issue(op, per, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                drain();
                fire();
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
